// File: rtl/generic_sram_byte_en_initiator.sv
// Byte-addressed load/store initiator for a generic byte-enable SRAM port.
// Each request becomes one or two word beats, with lane alignment, a word split and address wrap.
module generic_sram_byte_en_initiator #(
    parameter int ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_req_valid,
    output logic                                      o_req_ready,
    input  logic                                      i_req_write,
    input  logic [ADDRESS_WIDTH+$clog2(DATA_WIDTH/8)-1:0] i_req_addr,
    input  logic [1:0]                                i_req_size,
    input  logic [31:0]                               i_req_wdata,
    output logic                                      o_rsp_valid,
    input  logic                                      i_rsp_ready,
    output logic [31:0]                               o_rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0]                  o_sram_address,
    output logic                                      o_sram_write_enable,
    output logic [DATA_WIDTH/8-1:0]                   o_sram_byte_enable,
    output logic [DATA_WIDTH-1:0]                     o_sram_write_data,
    input  logic [DATA_WIDTH-1:0]                     i_sram_read_data
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int AW = ADDRESS_WIDTH + OB;

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, CAP, RSP} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] sram_addr_q;

    logic [AW-1:0]            addr_q;
    logic [1:0]               size_q;
    logic                     write_q;
    logic [31:0]              wdata_q;
    logic [31:0]              rdata_q;

    int                       off;
    int                       nbytes;
    int                       tail;
    logic                     split;
    logic                     req_fire;

    logic [NB-1:0]            be0;
    logic [NB-1:0]            be1;
    logic [DATA_WIDTH-1:0]    wd0;
    logic [DATA_WIDTH-1:0]    wd1;
    logic [31:0]              cap0;
    logic [31:0]              cap1;

    assign req_fire       = (state == IDLE) && i_req_valid;
    assign o_sram_address = sram_addr_q;

    // Beat decode: tail is the number of bytes spilling into the next word.
    always_comb begin
        off    = int'(addr_q[OB-1:0]);
        nbytes = (size_q == 2'd0) ? 1 : (size_q == 2'd1) ? 2 : 4;
        tail   = off + nbytes - NB;
        split  = (tail > 0);
        be0    = '0;
        be1    = '0;
        wd0    = '0;
        wd1    = '0;
        cap0   = '0;
        cap1   = '0;
        for (int l = 0; l < NB; l++) begin
            if (l >= off && l < off + nbytes) begin
                be0[l]                   = 1'b1;
                wd0[8*l +: 8]            = wdata_q[8*(l-off) +: 8];
                cap0[8*(l-off) +: 8]     = i_sram_read_data[8*l +: 8];
            end
            if (l < tail) begin
                be1[l]                   = 1'b1;
                wd1[8*l +: 8]            = wdata_q[8*(NB-off+l) +: 8];
                cap1[8*(NB-off+l) +: 8]  = i_sram_read_data[8*l +: 8];
            end
        end
    end

    // The word address is a register so it holds in IDLE yet clears immediately on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            sram_addr_q <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                sram_addr_q <= i_req_addr[AW-1:OB];
            end else if (state == BEAT0 && split) begin
                sram_addr_q <= sram_addr_q + ADDRESS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            addr_q  <= i_req_addr;
            size_q  <= i_req_size;
            write_q <= i_req_write;
            wdata_q <= i_req_wdata;
            rdata_q <= '0;
        end else if (state == BEAT1 && !write_q) begin
            rdata_q <= cap0;
        end else if (state == CAP) begin
            rdata_q <= split ? (rdata_q | cap1) : cap0;
        end
    end

    always_comb begin
        state_next          = state;
        o_req_ready         = 1'b0;
        o_rsp_valid         = 1'b0;
        o_rsp_rdata         = '0;
        o_sram_write_enable = 1'b0;
        o_sram_byte_enable  = '0;
        o_sram_write_data   = '0;
        case (state)
            IDLE: begin
                o_req_ready = !i_rst;
                if (i_req_valid) begin
                    state_next = BEAT0;
                end
            end
            BEAT0: begin
                o_sram_write_enable = write_q;
                o_sram_byte_enable  = be0;
                o_sram_write_data   = write_q ? wd0 : '0;
                if (split) begin
                    state_next = BEAT1;
                end else begin
                    state_next = write_q ? RSP : CAP;
                end
            end
            BEAT1: begin
                o_sram_write_enable = write_q;
                o_sram_byte_enable  = be1;
                o_sram_write_data   = write_q ? wd1 : '0;
                state_next          = write_q ? RSP : CAP;
            end
            CAP: begin
                state_next = RSP;
            end
            RSP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = rdata_q;
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_generic_sram_byte_en_initiator.sv
// Directed bench for generic_sram_byte_en_initiator with a behavioural byte-enable SRAM.
module tb_generic_sram_byte_en_initiator;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [8:0]  i_req_addr;
    logic [1:0]  i_req_size;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [6:0]  o_sram_address;
    logic        o_sram_write_enable;
    logic [3:0]  o_sram_byte_enable;
    logic [31:0] o_sram_write_data;
    logic [31:0] i_sram_read_data;

    logic [31:0] mem [128];
    logic        clr;
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    always #5 i_clk = ~i_clk;

    generic_sram_byte_en_initiator #(.ADDRESS_WIDTH(7), .DATA_WIDTH(32)) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_req_valid         (i_req_valid),
        .o_req_ready         (o_req_ready),
        .i_req_write         (i_req_write),
        .i_req_addr          (i_req_addr),
        .i_req_size          (i_req_size),
        .i_req_wdata         (i_req_wdata),
        .o_rsp_valid         (o_rsp_valid),
        .i_rsp_ready         (i_rsp_ready),
        .o_rsp_rdata         (o_rsp_rdata),
        .o_sram_address      (o_sram_address),
        .o_sram_write_enable (o_sram_write_enable),
        .o_sram_byte_enable  (o_sram_byte_enable),
        .o_sram_write_data   (o_sram_write_data),
        .i_sram_read_data    (i_sram_read_data)
    );

    // SRAM: one-cycle read latency, returns 0 after a write beat.
    always @(posedge i_clk) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            i_sram_read_data <= '0;
        end else if (|o_sram_byte_enable) begin
            if (o_sram_write_enable) begin
                for (int b = 0; b < 4; b++)
                    if (o_sram_byte_enable[b])
                        mem[o_sram_address][8*b +: 8] <= o_sram_write_data[8*b +: 8];
                i_sram_read_data <= '0;
            end else begin
                i_sram_read_data <= mem[o_sram_address];
            end
        end else begin
            i_sram_read_data <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic issue(input logic wr, input logic [8:0] a, input logic [1:0] sz,
                         input logic [31:0] wd);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = a;
        i_req_size  = sz;
        i_req_wdata = wd;
        chk("req_ready_idle", 32'(o_req_ready), 32'h1);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        cyc = 1;
        @(negedge i_clk);
    endtask

    task automatic beat(input string tag, input logic [6:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input bit chk_wd);
        chk({tag, "_addr"}, 32'(o_sram_address), 32'(a));
        chk({tag, "_we"}, 32'(o_sram_write_enable), 32'(we));
        chk({tag, "_be"}, 32'(o_sram_byte_enable), 32'(be));
        if (chk_wd) chk({tag, "_wdata"}, o_sram_write_data, wd);
    endtask

    task automatic wait_rsp(input string tag, input int exp_cyc, input logic [31:0] exp_rdata);
        while (!o_rsp_valid && cyc < 12) tick();
        chk({tag, "_rsp_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_rdata"}, o_rsp_rdata, exp_rdata);
        chk({tag, "_req_ready_busy"}, 32'(o_req_ready), 32'h0);
        if (i_rsp_ready) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst       = 1'b1;
        clr         = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = '0;
        i_req_size  = '0;
        i_req_wdata = '0;
        i_rsp_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req_ready", 32'(o_req_ready), 32'h0);
        chk("rst_addr", 32'(o_sram_address), 32'h0);
        chk("rst_be", 32'(o_sram_byte_enable), 32'h0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        i_rst = 1'b0;
        clr   = 1'b0;
        #1;

        // Aligned 4B store.
        issue(1'b1, 9'h010, 2'd2, 32'hDDCCBBAA);
        beat("st4_b0", 7'd4, 1'b1, 4'b1111, 32'hDDCCBBAA, 1'b1);
        wait_rsp("st4", 2, 32'h0);

        // 2B store straddling words 4/5.
        issue(1'b1, 9'h013, 2'd1, 32'h00002211);
        beat("st2_b0", 7'd4, 1'b1, 4'b1000, 32'h11000000, 1'b1);
        tick();
        beat("st2_b1", 7'd5, 1'b1, 4'b0001, 32'h00000022, 1'b1);
        wait_rsp("st2", 3, 32'h0);

        // Split 4B load.
        issue(1'b0, 9'h012, 2'd2, 32'h0);
        beat("ld4_b0", 7'd4, 1'b0, 4'b1100, 32'h0, 1'b0);
        tick();
        beat("ld4_b1", 7'd5, 1'b0, 4'b0011, 32'h0, 1'b0);
        wait_rsp("ld4", 4, 32'h002211CC);

        // Aligned 1B load.
        issue(1'b0, 9'h011, 2'd0, 32'h0);
        beat("ld1_b0", 7'd4, 1'b0, 4'b0010, 32'h0, 1'b0);
        wait_rsp("ld1", 3, 32'h000000BB);

        // Wrap: top word to word 0.
        issue(1'b1, 9'h1FF, 2'd1, 32'h0000BEEF);
        beat("wrap_st_b0", 7'd127, 1'b1, 4'b1000, 32'hEF000000, 1'b1);
        tick();
        beat("wrap_st_b1", 7'd0, 1'b1, 4'b0001, 32'h000000BE, 1'b1);
        wait_rsp("wrap_st", 3, 32'h0);
        issue(1'b0, 9'h1FF, 2'd1, 32'h0);
        wait_rsp("wrap_ld", 4, 32'h0000BEEF);

        // Response backpressure.
        i_rsp_ready = 1'b0;
        issue(1'b0, 9'h010, 2'd0, 32'h0);
        wait_rsp("bp", 3, 32'h000000AA);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(o_rsp_valid), 32'h1);
            chk("bp_rdata", o_rsp_rdata, 32'h000000AA);
            chk("bp_req_ready", 32'(o_req_ready), 32'h0);
        end
        i_rsp_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 32'(o_req_ready), 32'h1);
        chk("bp_idle_valid", 32'(o_rsp_valid), 32'h0);
        chk("idle_addr_hold", 32'(o_sram_address), 32'h4);
        chk("idle_be", 32'(o_sram_byte_enable), 32'h0);

        // Reset during BEAT1 of a split store to words 5/6.
        issue(1'b1, 9'h016, 2'd2, 32'h44332211);
        beat("rst_st_b0", 7'd5, 1'b1, 4'b1100, 32'h22110000, 1'b1);
        tick();
        beat("rst_st_b1", 7'd6, 1'b1, 4'b0011, 32'h00004433, 1'b1);
        i_rst = 1'b1;
        #1;
        chk("midrst_we", 32'(o_sram_write_enable), 32'h0);
        chk("midrst_be", 32'(o_sram_byte_enable), 32'h0);
        chk("midrst_addr", 32'(o_sram_address), 32'h0);
        chk("midrst_req_ready", 32'(o_req_ready), 32'h0);
        chk("midrst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("postrst_ready", 32'(o_req_ready), 32'h1);
        issue(1'b0, 9'h018, 2'd2, 32'h0);
        wait_rsp("word6_unchanged", 3, 32'h0);
        issue(1'b0, 9'h014, 2'd2, 32'h0);
        wait_rsp("word5_beat0", 3, 32'h22110022);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/generic_sram_byte_en_initiator.md
# generic_sram_byte_en_initiator

Master-side driver for the generic byte-enable SRAM port: accepts one byte-addressed load/store of 1, 2 or 4 bytes over a valid/ready request channel, converts it into one or two word accesses with per-byte enables, and returns a response over a valid/ready channel. It sits between a processor-like or test-sequence initiator and any generic_sram_byte_en_bfm instance. It handles lane alignment, word-straddling splits, address wrap and the SRAM's one-cycle read latency. One request is outstanding at a time.

## Interface
- ADDRESS_WIDTH, 7, SRAM word-address width.
- DATA_WIDTH, 32, SRAM word width; multiple of 8, >= 32. NB = DATA_WIDTH/8, OB = $clog2(NB).
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid&&ready at the clock edge.
- i_req_write  in  1  1=store, 0=load.
- i_req_addr  in  ADDRESS_WIDTH+OB  byte address.
- i_req_size  in  2  size code: 0=1B, 1=2B, 2=4B, 3=treated as 4B.
- i_req_wdata  in  32  store data, little-endian: byte k goes to address addr+k.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed when valid&&ready at the clock edge.
- o_rsp_rdata  out  32  load data, zero-extended; 0 for stores.
- o_sram_address  out  ADDRESS_WIDTH  SRAM word address.
- o_sram_write_enable  out  1  SRAM write strobe.
- o_sram_byte_enable  out  NB  SRAM lane enables.
- o_sram_write_data  out  DATA_WIDTH  SRAM write data.
- i_sram_read_data  in  DATA_WIDTH  SRAM read data, valid the cycle after a read beat.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, CAP, RSP.
- IDLE:
  - o_req_ready=1; all other outputs are 0, except o_sram_address, which holds its last value.
  - On handshake, register addr, size, write and wdata, then go to BEAT0.
- Beat decode:
  - off = addr[OB-1:0], word A = addr[top:OB], n = bytes from size.
  - A split occurs when off+n > NB.
- BEAT0:
  - Drive address A and write_enable=write.
  - byte_enable sets lanes off..min(off+n,NB)-1.
  - Write data places request byte k in lane off+k; unused lanes are 0.
  - Next state: if split, BEAT1; else if read, CAP; else RSP.
- BEAT1:
  - Drive address A+1, taken mod 2^ADDRESS_WIDTH so the address wraps to 0.
  - Lanes 0..off+n-NB-1 carry request bytes NB-off onward.
  - For reads, capture the BEAT0 lanes from i_sram_read_data during this cycle.
  - Next state: read goes to CAP, write goes to RSP.
- CAP: capture the last beat's enabled lanes into the response bytes, then go to RSP.
- RSP:
  - o_rsp_valid=1 and o_rsp_rdata hold stable; o_req_ready=0.
  - On i_rsp_ready, go to IDLE.
- Byte enables and write_enable are 0 in every state other than BEAT0 and BEAT1.
- Reset:
  - Asynchronous: state goes to IDLE and all outputs, including o_sram_address, go to 0 immediately.
  - Any in-flight request or beat is dropped; a BEAT1 not yet clocked is never written.

## Timing
- Request handshake at the end of cycle 0; BEAT0 is driven in cycle 1.
- o_rsp_valid first asserts in:
  - cycle 2 for an aligned store;
  - cycle 3 for a split store or an aligned load;
  - cycle 4 for a split load.
- Minimum request-to-request spacing is latency+1 cycles, since o_req_ready reasserts only in IDLE.
- With i_rsp_ready tied to 1, RSP lasts exactly one cycle.
- Read data is sampled exactly one cycle after its beat. The SRAM returns 0 after a write beat, so read and write beats are never mixed within one request.

## Test plan
DATA_WIDTH=32, ADDRESS_WIDTH=7, SRAM BFM preloaded with zeros.
- Store 4B at 0x010, data 0xDDCCBBAA.
  - One beat: addr 4, be 1111, wdata 0xDDCCBBAA.
  - rsp_valid in cycle 2, rdata 0.
- Store 2B at 0x013, data 0x2211.
  - BEAT0: addr 4, be 1000, wdata 0x11000000.
  - BEAT1: addr 5, be 0001, wdata 0x00000022.
  - rsp in cycle 3.
- Load 4B at 0x012 after the two stores.
  - Beats: addr 4 then addr 5, we=0.
  - rsp in cycle 4, rdata 0x002211CC.
- Load 1B at 0x011.
  - One beat: addr 4, be 0010.
  - rsp in cycle 3, rdata 0x000000BB.
- Store 2B at 0x1FF, data 0xBEEF (wrap case).
  - BEAT0: addr 127, be 1000.
  - BEAT1: addr 0, be 0001, wdata 0x000000BE.
  - A follow-up load of 2B at 0x1FF returns 0x0000BEEF.
- Backpressure and reset.
  - Hold i_rsp_ready=0 for 5 cycles: rsp_valid and rdata stay stable and o_req_ready stays 0.
  - Assert i_rst during BEAT1 of a split store: the same cycle shows write_enable=0, be=0, address 0 and state IDLE, and the word at A+1 is unchanged.
